sfx_speaker_arbiter: RTL and testbench
======================================

// Module: sfx_speaker_arbiter
// PURPOSE
//   Shares the single speaker output between N_SRC sound-effect tone generators
//   (punch, kick, block, KO, ...) and the background-music tone. Latches
//   one-shot play requests, picks one by fixed priority (index 0 highest), and
//   gates that source's square wave to the speaker for DUR_CYCLES. A higher
//   priority request preempts the current effect. Inserts GAP_CYCLES of silence
//   between effects. Music plays only when no effect is active.
// PARAMETERS
//   N_SRC       4           number of effect sources (2..8)
//   DUR_CYCLES  10_000_000  effect length in clk cycles (100 ms @ 100 MHz), >=1
//   GAP_CYCLES  500_000     silence between effects in clk cycles, 0 = no gap
//   SEL_W       $clog2(N_SRC)  width of active_src (derived, localparam)
// PORTS
//   clk         in   1      system clock
//   rst_n       in   1      synchronous active-low reset
//   req         in   N_SRC  play request per source; level sampled every edge
//   tone_in     in   N_SRC  square-wave tone per source (from CustomClock dividers)
//   music_tone  in   1      background-music square wave
//   music_en    in   1      1 = music audible while idle
//   speaker     out  1      registered audio output
//   busy        out  1      1 while state is PLAY or GAP
//   active_src  out  SEL_W  index of source in PLAY (0 when not playing)
//   ack         out  N_SRC  one-cycle pulse: request i granted
//   done        out  1      one-cycle pulse: effect finished its full duration
// BEHAVIOUR
// - Reset (rst_n=0 at an edge): state=IDLE, pending=0, counters=0, speaker=0,
//   busy=0, active_src=0, ack=0, done=0. Takes priority over every other event.
// - pending[N_SRC-1:0]: bit i set at any edge where req[i]=1; cleared at the
//   edge where i is granted. If req[i]=1 on the grant edge, the clear wins.
// - cand = pending | req. winner = lowest set index of cand.
// - FSM:
//   IDLE: if cand!=0: go to PLAY, active_src<=winner, cnt<=DUR_CYCLES-1,
//         ack[winner]<=1.
//   PLAY: if cand has a bit with index < active_src: preempt. Reload with the
//         new winner as in IDLE. Give ack. No done. The old effect is dropped.
//         Else if cnt==0: done<=1. If GAP_CYCLES>0, go to GAP, cnt<=GAP_CYCLES-1.
//         Else if cand!=0, start winner directly (as IDLE). Else go to IDLE.
//         Else cnt<=cnt-1.
//         A request for the current source is not a restart; it stays pending.
//   GAP:  if cnt==0: if cand!=0, start winner (as IDLE), else go to IDLE.
//         Else cnt<=cnt-1. Requests arriving in GAP only set pending
//         (no preemption of GAP).
// - PLAY lasts exactly DUR_CYCLES cycles. GAP lasts exactly GAP_CYCLES cycles.
// - cnt width = $clog2(max(DUR_CYCLES,GAP_CYCLES)+1). cnt never underflows.
// - busy = (state!=IDLE). active_src = 0 outside PLAY. ack/done are registered
//   pulses that are high for exactly one cycle.
// - speaker is registered, with 1-cycle latency from the current state:
//   PLAY -> tone_in[active_src]; IDLE -> music_tone & music_en; GAP -> 0.
// - Grant latency: req seen at edge k gives busy=1, ack, active_src after
//   edge k. The selected tone reaches speaker after edge k+1.
// - Reset mid-PLAY/GAP: silences immediately and discards pending. No done.
// TESTING (DUR_CYCLES=8, GAP_CYCLES=2, N_SRC=4)
// - Reset: rst_n=0 with req=4'b1111 and music_en=1 -> speaker=0, busy=0,
//   ack=0. After release with req=0: stays IDLE.
// - Single: 1-cycle req=4'b0100 at edge 0 -> ack=4'b0100 for 1 cycle,
//   active_src=2, busy high 10 cycles, done at cycle 8, speaker==tone_in[2]
//   delayed 1 cycle for 8 cycles, then 0 for 2 cycles.
// - Simultaneous: req=4'b0101 for 1 cycle -> src0 plays 8 cycles, gap 2,
//   src2 plays 8 cycles. ack pulses 0001 then 0100. done pulses twice.
// - Preempt: src3 playing at cnt=4, pulse req[1] -> next edge active_src=1,
//   ack=0010, no done for src3, src1 plays a full 8 cycles.
// - Music: idle, music_en=1, toggle music_tone -> speaker follows it 1 cycle
//   later. Muted through PLAY+GAP. music_en=0 -> speaker=0.
// - Reset mid-PLAY with req[3] pending -> after edge: IDLE, pending=0,
//   speaker=0, no done. Src3 does not play after release.

Source files
------------

// File: rtl/sfx_speaker_arbiter_if.sv
// Bundle of the arbiter's request, tone and speaker-side signals.
// master: the side that raises requests and supplies tones.
// slave:  the arbiter itself.
interface sfx_speaker_arbiter_if #(
  parameter int N_SRC = 4
) ();
  localparam int SEL_W = $clog2(N_SRC);

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] tone_in;
  logic             music_tone;
  logic             music_en;
  logic             speaker;
  logic             busy;
  logic [SEL_W-1:0] active_src;
  logic [N_SRC-1:0] ack;
  logic             done;

  modport master (
    output req, tone_in, music_tone, music_en,
    input  speaker, busy, active_src, ack, done
  );

  modport slave (
    input  req, tone_in, music_tone, music_en,
    output speaker, busy, active_src, ack, done
  );
endinterface

// File: rtl/sfx_speaker_arbiter.sv
// Sound-effect speaker arbiter: latches one-shot effect requests, plays the
// highest-priority one (index 0 wins) for DUR_CYCLES, lets a higher-priority
// request cut in, separates effects with GAP_CYCLES of silence, and lets the
// background music through only while idle.
module sfx_speaker_arbiter #(
  parameter int N_SRC      = 4,
  parameter int DUR_CYCLES = 10_000_000,
  parameter int GAP_CYCLES = 500_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sfx_speaker_arbiter_if.slave  bus
);

  localparam int SEL_W = $clog2(N_SRC);
  localparam int MAX_C = (DUR_CYCLES > GAP_CYCLES) ? DUR_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0] DUR_LOAD = CNT_W'(DUR_CYCLES - 1);
  // With no gap the load value is never used; keep it well defined anyway.
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] w_pending_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [SEL_W-1:0] r_active;
  logic [SEL_W-1:0] w_active_next;
  logic [N_SRC-1:0] r_ack;
  logic [N_SRC-1:0] w_ack_next;
  logic             r_done;
  logic             w_done_next;
  logic             r_speaker;
  logic             w_speaker_next;

  logic [N_SRC-1:0] w_cand;
  logic [SEL_W-1:0] w_winner;
  logic [N_SRC-1:0] w_below;
  logic             w_preempt;
  logic             w_grant;

  assign w_cand = r_pending | bus.req;

  // Lowest set index of the candidates wins (scan downward so index 0 lands last).
  always_comb begin
    w_winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_winner = SEL_W'(i);
      end
    end
  end

  // A candidate strictly above the playing source in priority may cut in.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_below
      assign w_below[gi] = w_cand[gi] && (SEL_W'(gi) < r_active);
    end
  endgenerate

  assign w_preempt = |w_below;

  // Next-state, counter, grant and pulse decode for the play/gap sequencer.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_active_next = r_active;
    w_ack_next    = '0;
    w_done_next   = 1'b0;
    w_grant       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (|w_cand) begin
          w_grant = 1'b1;
        end
      end
      S_PLAY: begin
        if (w_preempt) begin
          w_grant = 1'b1;
        end else if (r_cnt == '0) begin
          w_done_next = 1'b1;
          if (GAP_CYCLES > 0) begin
            w_state_next  = S_GAP;
            w_cnt_next    = GAP_LOAD;
            w_active_next = '0;
          end else if (|w_cand) begin
            w_grant = 1'b1;
          end else begin
            w_state_next  = S_IDLE;
            w_active_next = '0;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          if (|w_cand) begin
            w_grant = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next  = S_IDLE;
        w_cnt_next    = '0;
        w_active_next = '0;
      end
    endcase

    if (w_grant) begin
      w_state_next  = S_PLAY;
      w_active_next = w_winner;
      w_cnt_next    = DUR_LOAD;
      w_ack_next    = N_SRC'(1) << w_winner;
    end
  end

  // The grant one-hot doubles as the pending clear mask, so a clear beats a
  // request arriving on the same edge.
  assign w_pending_next = w_cand & ~w_ack_next;

  // Speaker source follows the state currently held, giving one cycle of latency.
  always_comb begin
    case (r_state)
      S_PLAY:  w_speaker_next = bus.tone_in[r_active];
      S_IDLE:  w_speaker_next = bus.music_tone & bus.music_en;
      default: w_speaker_next = 1'b0;
    endcase
  end

  // State and output registers; reset silences and forgets all requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_cnt     <= '0;
      r_active  <= '0;
      r_ack     <= '0;
      r_done    <= 1'b0;
      r_speaker <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      r_cnt     <= w_cnt_next;
      r_active  <= w_active_next;
      r_ack     <= w_ack_next;
      r_done    <= w_done_next;
      r_speaker <= w_speaker_next;
    end
  end

  assign bus.speaker    = r_speaker;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.active_src = r_active;
  assign bus.ack        = r_ack;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_sfx_speaker_arbiter.sv
// Directed bench for sfx_speaker_arbiter with DUR_CYCLES=8, GAP_CYCLES=2.
// Inputs change 1 ns after a rising edge; outputs are read at the same point.
module tb_sfx_speaker_arbiter;

  localparam int N_SRC = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sfx_speaker_arbiter_if #(.N_SRC(N_SRC)) bus ();

  sfx_speaker_arbiter #(
    .N_SRC      (N_SRC),
    .DUR_CYCLES (8),
    .GAP_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.req        = 4'b1111;
    bus.tone_in    = 4'b1111;
    bus.music_tone = 1'b1;
    bus.music_en   = 1'b1;
    tick();
    tick();
    checks++; if (bus.speaker !== 1'b0) begin errors++; $display("FAIL reset_speaker got %b exp 0", bus.speaker); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b exp 0000", bus.ack); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.active_src !== 2'd0) begin errors++; $display("FAIL reset_active got %0d exp 0", bus.active_src); end
    bus.req      = 4'b0000;
    bus.music_en = 1'b0;
    rst_n        = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy c=%0d got %b exp 0", c, bus.busy); end
      checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL reset_release_ack c=%0d got %b exp 0000", c, bus.ack); end
    end
    $display("test_reset complete");
  endtask

  task automatic test_single();
    logic       exp_spk;
    logic       exp_busy;
    logic       exp_done;
    logic [1:0] exp_act;
    bus.music_en = 1'b0;
    bus.tone_in  = 4'b0000;
    bus.req      = 4'b0100;
    tick();
    bus.req = 4'b0000;
    checks++; if (bus.ack !== 4'b0100) begin errors++; $display("FAIL single_ack got %b exp 0100", bus.ack); end
    checks++; if (bus.active_src !== 2'd2) begin errors++; $display("FAIL single_active got %0d exp 2", bus.active_src); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy0 got %b exp 1", bus.busy); end
    for (int c = 1; c <= 12; c++) begin
      bus.tone_in = c[0] ? 4'b0100 : 4'b1011;
      tick();
      exp_spk  = (c <= 8) ? c[0] : 1'b0;
      exp_busy = (c <= 9);
      exp_done = (c == 8);
      exp_act  = (c <= 7) ? 2'd2 : 2'd0;
      checks++; if (bus.speaker !== exp_spk) begin errors++; $display("FAIL single_speaker c=%0d got %b exp %b", c, bus.speaker, exp_spk); end
      checks++; if (bus.busy !== exp_busy) begin errors++; $display("FAIL single_busy c=%0d got %b exp %b", c, bus.busy, exp_busy); end
      checks++; if (bus.done !== exp_done) begin errors++; $display("FAIL single_done c=%0d got %b exp %b", c, bus.done, exp_done); end
      checks++; if (bus.active_src !== exp_act) begin errors++; $display("FAIL single_active c=%0d got %0d exp %0d", c, bus.active_src, exp_act); end
      checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL single_ack_low c=%0d got %b exp 0000", c, bus.ack); end
    end
    $display("test_single complete");
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ack;
    logic       exp_done;
    logic [1:0] exp_act;
    logic       exp_busy;
    logic       exp_spk;
    bus.music_en = 1'b0;
    bus.tone_in  = 4'b1111;
    bus.req      = 4'b0101;
    tick();
    bus.req = 4'b0000;
    checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL b2b_ack0 got %b exp 0001", bus.ack); end
    checks++; if (bus.active_src !== 2'd0) begin errors++; $display("FAIL b2b_active0 got %0d exp 0", bus.active_src); end
    for (int c = 1; c <= 20; c++) begin
      tick();
      exp_ack  = (c == 10) ? 4'b0100 : 4'b0000;
      exp_done = (c == 8) || (c == 18);
      exp_act  = (c >= 10 && c <= 17) ? 2'd2 : 2'd0;
      exp_busy = (c <= 19);
      exp_spk  = (c <= 8) || (c >= 11 && c <= 18);
      checks++; if (bus.ack !== exp_ack) begin errors++; $display("FAIL b2b_ack c=%0d got %b exp %b", c, bus.ack, exp_ack); end
      checks++; if (bus.done !== exp_done) begin errors++; $display("FAIL b2b_done c=%0d got %b exp %b", c, bus.done, exp_done); end
      checks++; if (bus.active_src !== exp_act) begin errors++; $display("FAIL b2b_active c=%0d got %0d exp %0d", c, bus.active_src, exp_act); end
      checks++; if (bus.busy !== exp_busy) begin errors++; $display("FAIL b2b_busy c=%0d got %b exp %b", c, bus.busy, exp_busy); end
      checks++; if (bus.speaker !== exp_spk) begin errors++; $display("FAIL b2b_speaker c=%0d got %b exp %b", c, bus.speaker, exp_spk); end
    end
    $display("test_back_to_back complete");
  endtask

  task automatic test_preempt();
    logic       exp_done;
    logic [1:0] exp_act;
    logic       exp_busy;
    logic       exp_spk;
    bus.music_en = 1'b0;
    bus.tone_in  = 4'b0010;
    bus.req      = 4'b1000;
    tick();
    bus.req = 4'b0000;
    checks++; if (bus.ack !== 4'b1000) begin errors++; $display("FAIL preempt_ack3 got %b exp 1000", bus.ack); end
    checks++; if (bus.active_src !== 2'd3) begin errors++; $display("FAIL preempt_active3 got %0d exp 3", bus.active_src); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (bus.active_src !== 2'd3) begin errors++; $display("FAIL preempt_hold3 c=%0d got %0d exp 3", c, bus.active_src); end
    end
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0000;
    checks++; if (bus.active_src !== 2'd1) begin errors++; $display("FAIL preempt_active1 got %0d exp 1", bus.active_src); end
    checks++; if (bus.ack !== 4'b0010) begin errors++; $display("FAIL preempt_ack1 got %b exp 0010", bus.ack); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL preempt_nodone got %b exp 0", bus.done); end
    for (int c = 5; c <= 15; c++) begin
      tick();
      exp_done = (c == 12);
      exp_act  = (c <= 11) ? 2'd1 : 2'd0;
      exp_busy = (c <= 13);
      exp_spk  = (c <= 12);
      checks++; if (bus.done !== exp_done) begin errors++; $display("FAIL preempt_done c=%0d got %b exp %b", c, bus.done, exp_done); end
      checks++; if (bus.active_src !== exp_act) begin errors++; $display("FAIL preempt_active c=%0d got %0d exp %0d", c, bus.active_src, exp_act); end
      checks++; if (bus.busy !== exp_busy) begin errors++; $display("FAIL preempt_busy c=%0d got %b exp %b", c, bus.busy, exp_busy); end
      checks++; if (bus.speaker !== exp_spk) begin errors++; $display("FAIL preempt_speaker c=%0d got %b exp %b", c, bus.speaker, exp_spk); end
      checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL preempt_ack_low c=%0d got %b exp 0000", c, bus.ack); end
    end
    $display("test_preempt complete");
  endtask

  task automatic test_music();
    bus.music_en = 1'b1;
    bus.tone_in  = 4'b0000;
    for (int c = 1; c <= 6; c++) begin
      bus.music_tone = c[0];
      tick();
      checks++; if (bus.speaker !== c[0]) begin errors++; $display("FAIL music_follow c=%0d got %b exp %b", c, bus.speaker, c[0]); end
    end
    bus.music_tone = 1'b1;
    bus.req        = 4'b0001;
    tick();
    bus.req = 4'b0000;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL music_start_busy got %b exp 1", bus.busy); end
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++; if (bus.speaker !== 1'b0) begin errors++; $display("FAIL music_muted c=%0d got %b exp 0", c, bus.speaker); end
    end
    tick();
    checks++; if (bus.speaker !== 1'b1) begin errors++; $display("FAIL music_resume got %b exp 1", bus.speaker); end
    bus.music_en = 1'b0;
    tick();
    tick();
    checks++; if (bus.speaker !== 1'b0) begin errors++; $display("FAIL music_disabled got %b exp 0", bus.speaker); end
    $display("test_music complete");
  endtask

  task automatic test_reset_mid_play();
    bus.music_en = 1'b0;
    bus.tone_in  = 4'b1111;
    bus.req      = 4'b0001;
    tick();
    bus.req = 4'b0000;
    tick();
    tick();
    bus.req = 4'b1000;
    tick();
    bus.req = 4'b0000;
    checks++; if (bus.active_src !== 2'd0) begin errors++; $display("FAIL rstmid_no_preempt got %0d exp 0", bus.active_src); end
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
    checks++; if (bus.speaker !== 1'b0) begin errors++; $display("FAIL rstmid_speaker got %b exp 0", bus.speaker); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", bus.done); end
    checks++; if (bus.active_src !== 2'd0) begin errors++; $display("FAIL rstmid_active got %0d exp 0", bus.active_src); end
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_after_busy c=%0d got %b exp 0", c, bus.busy); end
      checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL rstmid_after_ack c=%0d got %b exp 0000", c, bus.ack); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_after_done c=%0d got %b exp 0", c, bus.done); end
      checks++; if (bus.speaker !== 1'b0) begin errors++; $display("FAIL rstmid_after_speaker c=%0d got %b exp 0", c, bus.speaker); end
    end
    $display("test_reset_mid_play complete");
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.req        = '0;
    bus.tone_in    = '0;
    bus.music_tone = 1'b0;
    bus.music_en   = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_preempt();
    test_music();
    test_reset_mid_play();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
